// File: rtl/mem_bus_responder_if.sv
// Bus between the microprogrammed control section, the memory responder and its SRAM.
// The responder takes the slave modport; the control section and SRAM model take the master side.
interface mem_bus_responder_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              rd;
    logic              wr;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              busy;
    logic              err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  rd, wr, addr, wdata, mem_rdata,
        output rdata, ack, busy, err, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output rd, wr, addr, wdata, mem_rdata,
        input  rdata, ack, busy, err, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_bus_responder.sv
// Memory responder: serves MIR read/write strobes against a synchronous SRAM with WAIT_STATES extra cycles.
// Optional macro MEM_ALIGN_CHECK_EN turns misaligned requests into an immediate err+ack without touching memory.
module mem_bus_responder #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_bus_responder_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    state_t            r_state, w_state;
    logic [3:0]        r_cnt, w_cnt;
    logic              r_is_rd, w_is_rd;
    logic              r_ack, w_ack;
    logic              r_busy, w_busy;
    logic              r_err, w_err;
    logic              r_mem_en, w_mem_en;
    logic              r_mem_we, w_mem_we;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata;
    logic [DATA_W-1:0] r_rdata, w_rdata;
    logic              w_req;
    logic              w_misalign;
    logic              w_unused_bits;

    assign w_req = bus.rd | bus.wr;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign    = (bus.addr[1:0] != 2'b00);
    assign w_unused_bits = ^bus.addr[31:ADDR_W+2];
`else
    assign w_misalign    = 1'b0;
    assign w_unused_bits = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};
`endif

    // Next-state and next-output computation; every register holds unless a state says otherwise.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_is_rd     = r_is_rd;
        w_ack       = r_ack;
        w_busy      = r_busy;
        w_err       = r_err;
        w_mem_en    = r_mem_en;
        w_mem_we    = r_mem_we;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_rdata     = r_rdata;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_busy  = 1'b1;
                    w_is_rd = bus.rd;
                    if (w_misalign) begin
                        w_ack   = 1'b1;
                        w_err   = 1'b1;
                        w_state = S_ACK;
                    end else begin
                        w_mem_addr  = bus.addr[ADDR_W+1:2];
                        w_mem_wdata = bus.wdata;
                        w_mem_en    = 1'b1;
                        w_mem_we    = bus.wr & ~bus.rd;
                        w_state     = S_ACCESS;
                    end
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_ACCESS: begin
                w_mem_en = 1'b0;
                w_mem_we = 1'b0;
                w_cnt    = 4'(WAIT_STATES);
                w_state  = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_cnt = r_cnt - 4'd1;
                end else begin
                    w_ack   = 1'b1;
                    w_state = S_ACK;
                    // SRAM data has been stable since the cycle after mem_en.
                    if (r_is_rd) begin
                        w_rdata = bus.mem_rdata;
                    end else begin
                        w_rdata = r_rdata;
                    end
                end
            end
            S_ACK: begin
                w_ack   = 1'b0;
                w_err   = 1'b0;
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_is_rd     <= 1'b0;
            r_ack       <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= {DATA_W{1'b0}};
            r_rdata     <= {DATA_W{1'b0}};
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_is_rd     <= w_is_rd;
            r_ack       <= w_ack;
            r_busy      <= w_busy;
            r_err       <= w_err;
            r_mem_en    <= w_mem_en;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_rdata     <= w_rdata;
        end
    end

    assign bus.rdata     = r_rdata;
    assign bus.ack       = r_ack;
    assign bus.busy      = r_busy;
    assign bus.err       = r_err;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: one instance with two wait states, one with none.
module tb_mem_bus_responder;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   en2, we2, ack2, busy2, err2;
    int   en0, we0, ack0;
    int   cyc0, en0_at1, en0_at2;

    logic [31:0] mem2 [0:2047];
    logic [31:0] mem0 [0:2047];

    mem_bus_responder_if #(.ADDR_W(11), .DATA_W(32)) if2 ();
    mem_bus_responder_if #(.ADDR_W(11), .DATA_W(32)) if0 ();

    mem_bus_responder #(.ADDR_W(11), .DATA_W(32), .WAIT_STATES(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    mem_bus_responder #(.ADDR_W(11), .DATA_W(32), .WAIT_STATES(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    always #5 clk = ~clk;

    // Read-only synchronous SRAM models: data appears the cycle after mem_en.
    always @(posedge clk) begin
        if (if2.mem_en && !if2.mem_we) if2.mem_rdata <= mem2[if2.mem_addr];
        if (if0.mem_en && !if0.mem_we) if0.mem_rdata <= mem0[if0.mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        en2 = 0; we2 = 0; ack2 = 0; busy2 = 0; err2 = 0;
        en0 = 0; we0 = 0; ack0 = 0; cyc0 = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (if2.mem_en === 1'b1) en2++;
        if (if2.mem_we === 1'b1) we2++;
        if (if2.ack === 1'b1) ack2++;
        if (if2.busy === 1'b1) busy2++;
        if (if2.err === 1'b1) err2++;
        cyc0++;
        if (if0.mem_en === 1'b1) begin
            en0++;
            if (en0 == 1) en0_at1 = cyc0;
            if (en0 == 2) en0_at2 = cyc0;
        end
        if (if0.mem_we === 1'b1) we0++;
        if (if0.ack === 1'b1) ack0++;
    endtask

    initial begin
        clk = 1'b0; rst = 1'b0;
        n_vec = 0; n_err = 0; en0_at1 = 0; en0_at2 = 0;
        for (int i = 0; i < 2048; i++) begin
            mem2[i] = 32'h0000_0000;
            mem0[i] = 32'h0000_0000;
        end
        mem2[4] = 32'hDEAD_BEEF;
        mem2[2] = 32'hCAFE_F00D;
        mem0[2] = 32'hA5A5_0002;
        mem0[4] = 32'h0000_4444;
        if2.rd = 1'b0; if2.wr = 1'b0; if2.addr = 32'h0; if2.wdata = 32'h0;
        if0.rd = 1'b0; if0.wr = 1'b0; if0.addr = 32'h0; if0.wdata = 32'h0;
        clr();

        // Reset state
        step(); step();
        chk("rst_ack", {31'd0, if2.ack}, 32'd0);
        chk("rst_busy", {31'd0, if2.busy}, 32'd0);
        chk("rst_en", {31'd0, if2.mem_en}, 32'd0);
        chk("rst_maddr", {21'd0, if2.mem_addr}, 32'd0);
        chk("rst_rdata", if2.rdata, 32'd0);
        rst = 1'b1;
        step();

        // Read, two wait states
        if2.rd = 1'b1; if2.addr = 32'h0000_0010; clr();
        step();
        chk("rd_en", {31'd0, if2.mem_en}, 32'd1);
        chk("rd_we", {31'd0, if2.mem_we}, 32'd0);
        chk("rd_maddr", {21'd0, if2.mem_addr}, 32'd4);
        step();
        chk("rd_en_pulse", {31'd0, if2.mem_en}, 32'd0);
        step(); step();
        chk("rd_ack_early", {31'd0, if2.ack}, 32'd0);
        step();
        chk("rd_ack", {31'd0, if2.ack}, 32'd1);
        chk("rd_rdata", if2.rdata, 32'hDEAD_BEEF);
        if2.rd = 1'b0;
        step();
        chk("rd_ack_clr", {31'd0, if2.ack}, 32'd0);
        chk("rd_en_cnt", en2, 32'd1);
        chk("rd_ack_cnt", ack2, 32'd1);
        chk("rd_busy_cnt", busy2, 32'd5);

        // Write, two wait states
        if2.wr = 1'b1; if2.addr = 32'h0000_0024; if2.wdata = 32'h1234_5678; clr();
        step();
        chk("wr_en", {31'd0, if2.mem_en}, 32'd1);
        chk("wr_we", {31'd0, if2.mem_we}, 32'd1);
        chk("wr_maddr", {21'd0, if2.mem_addr}, 32'd9);
        chk("wr_mwdata", if2.mem_wdata, 32'h1234_5678);
        step(); step(); step(); step();
        chk("wr_ack", {31'd0, if2.ack}, 32'd1);
        chk("wr_rdata_keep", if2.rdata, 32'hDEAD_BEEF);
        if2.wr = 1'b0;
        step();
        chk("wr_we_cnt", we2, 32'd1);
        chk("wr_ack_cnt", ack2, 32'd1);

        // Reset while in WAIT, then a normal read of 0x8
        if2.rd = 1'b1; if2.addr = 32'h0000_0008; clr();
        step(); step();
        rst = 1'b0;
        #1;
        chk("mid_busy", {31'd0, if2.busy}, 32'd0);
        chk("mid_rdata", if2.rdata, 32'd0);
        chk("mid_maddr", {21'd0, if2.mem_addr}, 32'd0);
        step(); step();
        chk("mid_no_ack", ack2, 32'd0);
        rst = 1'b1; clr();
        step();
        chk("post_en", {31'd0, if2.mem_en}, 32'd1);
        chk("post_maddr", {21'd0, if2.mem_addr}, 32'd2);
        step(); step(); step(); step();
        chk("post_ack", {31'd0, if2.ack}, 32'd1);
        chk("post_rdata", if2.rdata, 32'hCAFE_F00D);
        if2.rd = 1'b0;
        step();

        // Back-to-back reads with no wait states; request toggles in WAIT ignored
        if0.rd = 1'b1; if0.addr = 32'h0000_0008; clr();
        step(); step(); step();
        chk("b2b_ack1", {31'd0, if0.ack}, 32'd1);
        chk("b2b_rdata1", if0.rdata, 32'hA5A5_0002);
        step(); step(); step();
        if0.wr = 1'b1; if0.addr = 32'h0000_0040;
        step();
        chk("b2b_ack2", {31'd0, if0.ack}, 32'd1);
        if0.rd = 1'b0; if0.wr = 1'b0;
        step(); step(); step();
        chk("b2b_en_cnt", en0, 32'd2);
        chk("b2b_en_gap", en0_at2 - en0_at1, 32'd4);
        chk("b2b_ack_cnt", ack0, 32'd2);
        chk("b2b_we_cnt", we0, 32'd0);

        // Simultaneous rd and wr is a read
        if0.rd = 1'b1; if0.wr = 1'b1; if0.addr = 32'h0000_0010; if0.wdata = 32'hFFFF_FFFF; clr();
        step();
        chk("rw_en", {31'd0, if0.mem_en}, 32'd1);
        step(); step();
        chk("rw_rdata", if0.rdata, 32'h0000_4444);
        if0.rd = 1'b0; if0.wr = 1'b0;
        step(); step();
        chk("rw_we_cnt", we0, 32'd0);
        chk("rw_ack_cnt", ack0, 32'd1);

        // Misaligned read of 0x13
        if2.rd = 1'b1; if2.addr = 32'h0000_0013; clr();
        step();
`ifdef MEM_ALIGN_CHECK_EN
        chk("mis_ack", {31'd0, if2.ack}, 32'd1);
        chk("mis_err", {31'd0, if2.err}, 32'd1);
        chk("mis_busy", {31'd0, if2.busy}, 32'd1);
        if2.rd = 1'b0;
        step(); step();
        chk("mis_err_clr", {31'd0, if2.err}, 32'd0);
        chk("mis_en_cnt", en2, 32'd0);
        chk("mis_rdata", if2.rdata, 32'hCAFE_F00D);
`else
        chk("mis_en", {31'd0, if2.mem_en}, 32'd1);
        chk("mis_maddr", {21'd0, if2.mem_addr}, 32'd4);
        step(); step(); step(); step();
        chk("mis_ack", {31'd0, if2.ack}, 32'd1);
        chk("mis_rdata", if2.rdata, 32'hDEAD_BEEF);
        if2.rd = 1'b0;
        step(); step();
        chk("mis_err_cnt", err2, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
